// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer
// Hard-wired Mini SRC control unit: fetch/execute sequencing and datapath strobes.
// Optional feature macro: CU_MEM_WAIT_EN (memory states stall until mem_done).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic        mem_done,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        IRin,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_F0   = 4'd1;
  localparam logic [3:0] S_F1   = 4'd2;
  localparam logic [3:0] S_F2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [4:0] w_opcode;
  logic       w_alu_reg;
  logic       w_alu_imm;
  logic       w_ld;
  logic       w_ldi;
  logic       w_st;
  logic       w_nop;
  logic       w_halt;
  logic       w_mem_ok;
  logic [4:0] w_imm_op;
  logic       w_unused;

  // IR is the datapath's own register, so T3..T7 decode straight from it.
  assign w_opcode  = IR[31:27];
  assign w_alu_reg = (w_opcode == OP_ADD) || (w_opcode == OP_SUB) ||
                     (w_opcode == OP_AND) || (w_opcode == OP_OR);
  assign w_alu_imm = (w_opcode == OP_ADDI) || (w_opcode == OP_ANDI) ||
                     (w_opcode == OP_ORI);
  assign w_ld      = (w_opcode == OP_LD);
  assign w_ldi     = (w_opcode == OP_LDI);
  assign w_st      = (w_opcode == OP_ST);
  assign w_nop     = (w_opcode == OP_NOP);
  assign w_halt    = (w_opcode == OP_HALT);

`ifdef CU_MEM_WAIT_EN
  assign w_mem_ok = mem_done;
  assign w_unused = ^IR[26:0];
`else
  assign w_mem_ok = 1'b1;
  assign w_unused = ^{IR[26:0], mem_done};
`endif

  always_comb begin
    w_imm_op = OP_ADD;
    case (w_opcode)
      OP_ANDI: w_imm_op = OP_AND;
      OP_ORI:  w_imm_op = OP_OR;
      default: w_imm_op = OP_ADD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_F0;
      S_F0:   state_d = S_F1;
      S_F1:   if (w_mem_ok) state_d = S_F2;
      S_F2:   state_d = S_T3;
      S_T3: begin
        if (w_halt)
          state_d = S_HALT;
        else if (w_alu_reg || w_alu_imm || w_ld || w_ldi || w_st)
          state_d = S_T4;
        else
          state_d = S_F0;
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = (w_ld || w_st) ? S_T6 : S_F0;
      S_T6: begin
        // Only the ld read in T6 touches memory; st T6 is a bus transfer.
        if (w_st || w_mem_ok) state_d = S_T7;
      end
      S_T7: begin
        if (w_ld || w_mem_ok) state_d = S_F0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    Cout    = 1'b0;
    PCout   = 1'b0;
    PCin    = 1'b0;
    IncPC   = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    IRin    = 1'b0;
    alu_op  = 5'b00000;
    illegal = 1'b0;
    run     = (state_q != S_IDLE) && (state_q != S_HALT);

    case (state_q)
      S_F0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_F1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_F2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (w_alu_reg || w_alu_imm) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (w_ld || w_ldi || w_st) begin
          Grb   = 1'b1;
          Rout  = 1'b1;
          BAout = 1'b1;
          Yin   = 1'b1;
        end else if (!w_nop && !w_halt) begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        Zin = 1'b1;
        if (w_alu_reg) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          alu_op = w_opcode;
        end else if (w_alu_imm) begin
          Cout   = 1'b1;
          alu_op = w_imm_op;
        end else begin
          Cout   = 1'b1;
          alu_op = OP_ADD;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (w_ld || w_st) begin
          MARin = 1'b1;
        end else begin
          Gra = 1'b1;
          Rin = 1'b1;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (w_st) begin
          Gra  = 1'b1;
          Rout = 1'b1;
        end else begin
          Read = 1'b1;
        end
      end
      S_T7: begin
        if (w_st) begin
          Write = 1'b1;
        end else begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
